salsa20_stream_ctrl: RTL and testbench
======================================

Name: salsa20_stream_ctrl

Overview:
- Sequences one Salsa20DoubleKeys keystream core to encrypt or decrypt a message of N 64-bit words.
- Issues init, requests 512-bit blocks with next_chunk, and buffers the 8 returned 64-bit chunk words.
- XORs the buffered words with an input data stream under valid/ready handshakes, and reports completion and the number of blocks consumed.
- Sits between the message DMA/stream path and the keystream core.

Parameters:
- LEN_W, 32, width of the message word count and of the block counter.
- WORDS_PER_BLOCK, 8, 64-bit chunk words per keystream block. Fixed at 8; other values unsupported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  one-cycle pulse; accepted only in IDLE.
- abort  in  1  synchronous abort; any state returns to IDLE next cycle.
- cfg_rounds  in  4  double-round count; sampled at start.
- cfg_keylength  in  1  1 = 256-bit key, 0 = 128-bit key; sampled at start.
- cfg_key  in  256  key; sampled at start.
- cfg_nonce  in  64  nonce; sampled at start.
- msg_words  in  LEN_W  message length in 64-bit words; sampled at start.
- in_valid  in  1  input data word valid.
- in_data  in  64  plaintext or ciphertext word.
- in_ready  out  1  controller accepts in_data this cycle.
- out_valid  out  1  output word valid.
- out_data  out  64  in_data XOR keystream word.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the last output word is accepted.
- blocks_used  out  LEN_W  keystream blocks fetched for the current/last message.
- core_init  out  1  to core init; held high from INIT until the message ends.
- core_rounds, core_keylength, core_key, core_nonce  out  4/1/256/64  registered copies of the cfg_* inputs.
- core_next_chunk  out  1  to core next_chunk.
- core_ready  in  1  core has a block available.
- core_valid  in  1  core_chunk_key carries a valid word.
- core_chunk_key  in  64  keystream word; the first word is bits [511:448] of the block.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, blocks_used=0, core_init=0, core_next_chunk=0, all config registers 0. State = IDLE.

State machine (IDLE, INIT, FETCH, STREAM, FLUSH):
- IDLE
  - start with msg_words=0: go to FLUSH.
  - start with msg_words>0: latch cfg_*, load remaining=msg_words, clear blocks_used, go to INIT.
- INIT
  - core_init=1.
  - On core_ready=1: go to FETCH.
- FETCH
  - core_next_chunk=1 beginning the cycle after FETCH is entered.
  - Each core_valid=1 writes core_chunk_key into buf[wr_idx] and increments wr_idx.
  - After the 8th word: deassert core_next_chunk, increment blocks_used, set rd_idx=0, go to STREAM.
  - core_valid while wr_idx=8 is ignored.
- STREAM
  - in_ready = !out_valid || out_ready.
  - Transfer condition: in_valid && in_ready.
  - On transfer: out_data <= in_data ^ buf[rd_idx], out_valid <= 1, rd_idx++, remaining--.
  - remaining reaches 0: go to FLUSH.
  - Otherwise rd_idx reaches 8: clear wr_idx, wait for core_ready, then go to FETCH.
  - Unused words of a partial final block are discarded; no further block is requested.
- FLUSH
  - in_ready=0.
  - Once out_valid=0 or out_ready=1 (last word leaving): pulse done, drop core_init, go to IDLE.
  - For msg_words=0, done pulses the cycle after start, with blocks_used=0 and no core_init assertion.

Output handshake:
- out_valid stays high and out_data stays stable until out_ready=1.
- Simultaneous out_ready and a new transfer: the register is reloaded, out_valid stays 1.

Boundary rules:
- Latency: in_data accepted at edge k appears on out_data after edge k, i.e. one register stage.
- Throughput: 1 word/clk within a block; each refetch stalls in_ready for core latency + 8 cycles.
- start outside IDLE: ignored.
- abort: takes priority over all other events. Clears out_valid, core_init and core_next_chunk; no done pulse. blocks_used keeps its value.
- Counters wrap modulo 2^LEN_W; messages longer than 2^LEN_W-1 are not supported.
- Reset asserted mid-message: all outputs return to reset values immediately, independent of clk.

Test Plan:
- Basic vector: key=0102030405060708090a0b0c0d0e0f10c9cacbcccdcecfd0d1d2d3d4d5d6d7d8, nonce=65666768696a6b6c, rounds=10, keylength=1, msg_words=8, in_data=0, out_ready=1 -> out_data sequence a09b7719223218a8, fba5a33dbf01a538, …, 7bed3d88a8afbb94; done pulses once; blocks_used=1.
- Multi-block: same config, msg_words=32 of zeros -> word 8 = 3432b110b86e67d7, word 16 = 235bbbc5877a4a9a, word 24 = db3467fb7ccbe9e9; blocks_used=4.
- Partial block plus round-trip: msg_words=10, in_data=ffffffffffffffff -> word 9 = ~3432b110b86e67d7 ^ …, done after word 10, blocks_used=2. Feeding the outputs back through a second run gives all-ones.
- Backpressure: out_ready toggling 1,0,0,1 -> no word lost or duplicated, out_data held stable while stalled, in_ready=0 while out_valid && !out_ready.
- Zero length and abort: msg_words=0 -> done the cycle after start, core_init never high. abort during FETCH of block 2 -> next cycle busy=0, core_init=0, no done.
- Async reset: assert rst=0 mid-STREAM between clock edges -> out_valid, busy, core_init go to 0 immediately. After release, a new start produces the basic-vector result.

Source files
------------

// File: rtl/salsa20_stream_ctrl_if.sv
// Stream and keystream-core handshake bundle for salsa20_stream_ctrl.
// master = controller side; slave = data source/sink and core side.
interface salsa20_stream_ctrl_if;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic        core_next_chunk;
  logic        core_ready;
  logic        core_valid;
  logic [63:0] core_chunk_key;

  modport master (
    input  in_valid, in_data, out_ready,
    input  core_ready, core_valid, core_chunk_key,
    output in_ready, out_valid, out_data,
    output core_next_chunk
  );

  modport slave (
    output in_valid, in_data, out_ready,
    output core_ready, core_valid, core_chunk_key,
    input  in_ready, out_valid, out_data,
    input  core_next_chunk
  );
endinterface

// File: rtl/salsa20_stream_ctrl.sv
// Salsa20 keystream sequencer: buffers 8-word blocks, XORs the data stream.
// Ports: clk/rst, start/abort, cfg_* in, busy/done/blocks_used, core_* out, bus.
module salsa20_stream_ctrl #(
  parameter int LEN_W           = 32,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           cfg_rounds,
  input  logic                 cfg_keylength,
  input  logic [255:0]         cfg_key,
  input  logic [63:0]          cfg_nonce,
  input  logic [LEN_W-1:0]     msg_words,
  salsa20_stream_ctrl_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     blocks_used,
  output logic                 core_init,
  output logic [3:0]           core_rounds,
  output logic                 core_keylength,
  output logic [255:0]         core_key,
  output logic [63:0]          core_nonce
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FETCH,
    S_STREAM,
    S_FLUSH
  } state_e;

  localparam logic [3:0] LAST = 4'(WORDS_PER_BLOCK - 1);
  localparam logic [3:0] FULL = 4'(WORDS_PER_BLOCK);

  state_e             state_q;
  logic [63:0]        kbuf_q [8];
  logic [3:0]         wr_idx_q;
  logic [3:0]         rd_idx_q;
  logic [LEN_W-1:0]   remain_q;
  logic [LEN_W-1:0]   blocks_q;
  logic               out_valid_q;
  logic [63:0]        out_data_q;
  logic               init_q;
  logic               next_q;
  logic [3:0]         rounds_q;
  logic               keylen_q;
  logic [255:0]       key_q;
  logic [63:0]        nonce_q;
  logic               xfer;
  logic               drain_ok;

  // Output register is free when empty or being emptied this cycle.
  assign drain_ok = !out_valid_q || bus.out_ready;

  // rd_idx == FULL means the block is spent and a refetch is pending.
  assign bus.in_ready = !abort && (state_q == S_STREAM) &&
                        (rd_idx_q != FULL) && drain_ok;
  assign xfer = bus.in_valid && bus.in_ready;

  assign done = !abort && (state_q == S_FLUSH) && drain_ok;
  assign busy = (state_q != S_IDLE);

  assign bus.out_valid       = out_valid_q;
  assign bus.out_data        = out_data_q;
  assign bus.core_next_chunk = next_q;
  assign blocks_used         = blocks_q;
  assign core_init           = init_q;
  assign core_rounds         = rounds_q;
  assign core_keylength      = keylen_q;
  assign core_key            = key_q;
  assign core_nonce          = nonce_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < 8; i++) kbuf_q[i] <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      remain_q    <= '0;
      blocks_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      init_q      <= 1'b0;
      next_q      <= 1'b0;
      rounds_q    <= '0;
      keylen_q    <= 1'b0;
      key_q       <= '0;
      nonce_q     <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data ^ kbuf_q[rd_idx_q[2:0]];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (abort) begin
        state_q     <= S_IDLE;
        out_valid_q <= 1'b0;
        init_q      <= 1'b0;
        next_q      <= 1'b0;
        wr_idx_q    <= '0;
        rd_idx_q    <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              blocks_q <= '0;
              if (msg_words == '0) begin
                state_q <= S_FLUSH;
              end else begin
                rounds_q <= cfg_rounds;
                keylen_q <= cfg_keylength;
                key_q    <= cfg_key;
                nonce_q  <= cfg_nonce;
                remain_q <= msg_words;
                wr_idx_q <= '0;
                init_q   <= 1'b1;
                state_q  <= S_INIT;
              end
            end
          end
          S_INIT: begin
            if (bus.core_ready) state_q <= S_FETCH;
          end
          S_FETCH: begin
            if (bus.core_valid && wr_idx_q != FULL) begin
              kbuf_q[wr_idx_q[2:0]] <= bus.core_chunk_key;
              wr_idx_q <= wr_idx_q + 4'd1;
            end
            if (bus.core_valid && wr_idx_q == LAST) begin
              next_q   <= 1'b0;
              blocks_q <= blocks_q + LEN_W'(1);
              rd_idx_q <= '0;
              state_q  <= S_STREAM;
            end else begin
              next_q <= 1'b1;
            end
          end
          S_STREAM: begin
            if (xfer) begin
              rd_idx_q <= rd_idx_q + 4'd1;
              remain_q <= remain_q - LEN_W'(1);
              if (remain_q == LEN_W'(1)) begin
                state_q <= S_FLUSH;
              end else if (rd_idx_q == LAST) begin
                wr_idx_q <= '0;
              end
            end else if (rd_idx_q == FULL &&
                         bus.core_ready) begin
              state_q <= S_FETCH;
            end
          end
          S_FLUSH: begin
            if (drain_ok) begin
              init_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_salsa20_stream_ctrl.sv
// Directed bench for salsa20_stream_ctrl with a stub keystream core.
// Covers basic, multi-block, partial, backpressure, zero-length, abort, reset.
module tb_salsa20_stream_ctrl;

  localparam int LEN_W = 32;
  localparam logic [255:0] KEY =
    256'h0102030405060708090a0b0c0d0e0f10c9cacbcccdcecfd0d1d2d3d4d5d6d7d8;
  localparam logic [63:0] NONCE = 64'h65666768696a6b6c;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [3:0]       cfg_rounds = 4'd10;
  logic             cfg_keylength = 1'b1;
  logic [255:0]     cfg_key = KEY;
  logic [63:0]      cfg_nonce = NONCE;
  logic [LEN_W-1:0] msg_words = '0;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] blocks_used;
  logic             core_init;
  logic [3:0]       core_rounds;
  logic             core_keylength;
  logic [255:0]     core_key;
  logic [63:0]      core_nonce;

  salsa20_stream_ctrl_if bus();

  always #5 clk = ~clk;

  salsa20_stream_ctrl #(.LEN_W(LEN_W), .WORDS_PER_BLOCK(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_rounds     (cfg_rounds),
    .cfg_keylength  (cfg_keylength),
    .cfg_key        (cfg_key),
    .cfg_nonce      (cfg_nonce),
    .msg_words      (msg_words),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .blocks_used    (blocks_used),
    .core_init      (core_init),
    .core_rounds    (core_rounds),
    .core_keylength (core_keylength),
    .core_key       (core_key),
    .core_nonce     (core_nonce)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Stub keystream: known words at the spots the test vectors name.
  function automatic logic [63:0] ks(input int b, input int j);
    if (b == 0 && j == 0) return 64'ha09b7719223218a8;
    if (b == 0 && j == 1) return 64'hfba5a33dbf01a538;
    if (b == 0 && j == 7) return 64'h7bed3d88a8afbb94;
    if (b == 1 && j == 0) return 64'h3432b110b86e67d7;
    if (b == 2 && j == 0) return 64'h235bbbc5877a4a9a;
    if (b == 3 && j == 0) return 64'hdb3467fb7ccbe9e9;
    return {32'h5A170000 | 32'(b), 32'hC0DE0000 | 32'(j)};
  endfunction

  logic sb_gen;
  int   sb_cnt, sb_dly, sb_blk;

  // Core model: ready a few cycles after init, then 8 words plus one
  // stray valid beat per next_chunk request.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.core_ready     <= 1'b0;
      bus.core_valid     <= 1'b0;
      bus.core_chunk_key <= '0;
      sb_gen <= 1'b0; sb_cnt <= 0; sb_dly <= 0; sb_blk <= 0;
    end else if (!core_init) begin
      bus.core_ready <= 1'b0;
      bus.core_valid <= 1'b0;
      sb_gen <= 1'b0; sb_cnt <= 0; sb_dly <= 0; sb_blk <= 0;
    end else if (sb_gen) begin
      if (sb_cnt == 9) begin
        bus.core_valid <= 1'b0;
        sb_gen <= 1'b0;
        sb_blk <= sb_blk + 1;
        sb_dly <= 0;
      end else begin
        bus.core_valid     <= 1'b1;
        bus.core_chunk_key <= (sb_cnt == 8) ? 64'hDEADBEEFDEADBEEF
                                            : ks(sb_blk, sb_cnt);
        sb_cnt <= sb_cnt + 1;
      end
    end else if (!bus.core_ready) begin
      if (sb_dly == 2) bus.core_ready <= 1'b1;
      else sb_dly <= sb_dly + 1;
    end else if (bus.core_next_chunk) begin
      bus.core_ready <= 1'b0;
      sb_gen <= 1'b1;
      sb_cnt <= 0;
    end
  end

  logic [63:0] in_mem [64];
  logic [63:0] out_mem [64];
  int n_out, n_done, done_cyc, hold_err, stall_err;
  bit saw_init;

  // mode: 0 plain, 1 out_ready 1,0,0,1, 2 abort in block-2 fetch,
  // 3 async reset after three output words.
  task automatic run(input int n, input int mode);
    int ii = 0;
    int cyc = 0;
    int tail = -1;
    int ab = 0;
    bit ab_chk = 0;
    bit stalled = 0;
    logic [63:0] held = '0;
    n_out = 0; n_done = 0; done_cyc = -1;
    hold_err = 0; stall_err = 0; saw_init = 0;
    while (1) begin
      @(posedge clk); #1;
      start = (cyc == 0);
      msg_words = LEN_W'(n);
      if (ab == 1) begin
        abort = 1'b1; ab = 2; tail = 6;
      end else begin
        abort = 1'b0;
      end
      bus.in_valid = (ii < n);
      bus.in_data  = (ii < n) ? in_mem[ii] : '0;
      bus.out_ready = (mode != 1) || (cyc % 4 == 0) || (cyc % 4 == 3);
      @(negedge clk);
      if (core_init) saw_init = 1;
      if (stalled && (!bus.out_valid || bus.out_data !== held))
        hold_err++;
      if (bus.out_valid && !bus.out_ready && bus.in_ready)
        stall_err++;
      stalled = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      if (bus.in_valid && bus.in_ready) ii++;
      if (bus.out_valid && bus.out_ready) begin
        if (n_out < 64) out_mem[n_out] = bus.out_data;
        n_out++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
        if (tail < 0) tail = 3;
      end
      if (ab == 3 && !ab_chk) begin
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_core_init", 64'(core_init), 64'd0);
        check("abort_next_chunk", 64'(bus.core_next_chunk), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        ab_chk = 1;
      end
      if (ab == 2) ab = 3;
      if (mode == 2 && ab == 0 && bus.core_next_chunk &&
          blocks_used == LEN_W'(1))
        ab = 1;
      if (mode == 3 && n_out >= 3) begin
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_core_init", 64'(core_init), 64'd0);
        break;
      end
      cyc++;
      if (tail > 0) tail--;
      if (tail == 0) break;
      if (cyc > 2000) begin
        check("timeout", 64'd1, 64'd0);
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    if (mode == 3) begin
      @(negedge clk);
      rst = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic int bad_words(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (out_mem[i] !== (in_mem[i] ^ ks(i / 8, i % 8))) bad++;
    return bad;
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_blocks", 64'(blocks_used), 64'd0);
    check("rst_core_init", 64'(core_init), 64'd0);
    check("rst_next_chunk", 64'(bus.core_next_chunk), 64'd0);
    check("rst_core_key_lo", core_key[63:0], 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 64; i++) in_mem[i] = '0;
    run(8, 0);
    check("basic_w0", out_mem[0], 64'ha09b7719223218a8);
    check("basic_w1", out_mem[1], 64'hfba5a33dbf01a538);
    check("basic_w7", out_mem[7], 64'h7bed3d88a8afbb94);
    check("basic_all", 64'(bad_words(8)), 64'd0);
    check("basic_count", 64'(n_out), 64'd8);
    check("basic_done", 64'(n_done), 64'd1);
    check("basic_blocks", 64'(blocks_used), 64'd1);
    check("basic_busy", 64'(busy), 64'd0);
    check("cfg_key_hi", core_key[255:192], 64'h0102030405060708);
    check("cfg_key_lo", core_key[63:0], 64'hd1d2d3d4d5d6d7d8);
    check("cfg_nonce", core_nonce, 64'h65666768696a6b6c);
    check("cfg_rounds", 64'(core_rounds), 64'd10);
    check("cfg_keylen", 64'(core_keylength), 64'd1);

    run(32, 0);
    check("multi_w8", out_mem[8], 64'h3432b110b86e67d7);
    check("multi_w16", out_mem[16], 64'h235bbbc5877a4a9a);
    check("multi_w24", out_mem[24], 64'hdb3467fb7ccbe9e9);
    check("multi_all", 64'(bad_words(32)), 64'd0);
    check("multi_count", 64'(n_out), 64'd32);
    check("multi_blocks", 64'(blocks_used), 64'd4);

    for (int i = 0; i < 64; i++) in_mem[i] = '1;
    run(10, 0);
    check("part_w8", out_mem[8], 64'hcbcd4eef47919828);
    check("part_w9", out_mem[9], 64'ha5e8fffe3f21fffe);
    check("part_count", 64'(n_out), 64'd10);
    check("part_done", 64'(n_done), 64'd1);
    check("part_blocks", 64'(blocks_used), 64'd2);
    for (int i = 0; i < 10; i++) in_mem[i] = out_mem[i];
    run(10, 0);
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++)
        if (out_mem[i] !== 64'hFFFFFFFFFFFFFFFF) bad++;
      check("roundtrip", 64'(bad), 64'd0);
    end

    for (int i = 0; i < 64; i++) in_mem[i] = 64'(i) * 64'h0101010101010101;
    run(16, 1);
    check("bp_all", 64'(bad_words(16)), 64'd0);
    check("bp_count", 64'(n_out), 64'd16);
    check("bp_hold", 64'(hold_err), 64'd0);
    check("bp_in_ready", 64'(stall_err), 64'd0);
    check("bp_done", 64'(n_done), 64'd1);

    run(0, 0);
    check("zero_done_cyc", 64'(done_cyc), 64'd1);
    check("zero_done_cnt", 64'(n_done), 64'd1);
    check("zero_no_init", 64'(saw_init), 64'd0);
    check("zero_blocks", 64'(blocks_used), 64'd0);

    run(16, 2);
    check("abort_no_done", 64'(n_done), 64'd0);
    check("abort_blocks", 64'(blocks_used), 64'd1);

    for (int i = 0; i < 64; i++) in_mem[i] = '0;
    run(16, 3);
    check("arst_blocks", 64'(blocks_used), 64'd0);
    run(8, 0);
    check("post_rst_w0", out_mem[0], 64'ha09b7719223218a8);
    check("post_rst_w7", out_mem[7], 64'h7bed3d88a8afbb94);
    check("post_rst_blocks", 64'(blocks_used), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
